// File: rtl/conv2d_fmap_broadcast_collect.sv
// conv2d feature-map front/back-end: one shared pixel FIFO broadcast to NF
// filter lanes, lane results collected round-robin. Optional CONV_FMAP_RELU_EN.
module conv2d_fmap_broadcast_collect #(
  parameter int DWIDTH    = 32,
  parameter int CH        = 3,
  parameter int NF        = 8,
  parameter int DEPTH     = 12544,
  parameter int FRAME_LEN = 12544,
  parameter int TAGW      = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CH*DWIDTH-1:0] fifo_in_data,
  input  logic                 fifo_in_wrreq,
  output logic                 fifo_in_full,
  output logic [CH*DWIDTH-1:0] lane_wdata,
  output logic [NF-1:0]        lane_wrreq,
  input  logic [NF-1:0]        lane_full,
  input  logic [NF*DWIDTH-1:0] res_data,
  input  logic [NF-1:0]        res_empty,
  output logic [NF-1:0]        res_rdreq,
  output logic [DWIDTH-1:0]    out_data,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int WW = CH * DWIDTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [WW-1:0]     mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [NF-1:0]     done_mask;
  logic [NF-1:0]     mask_all;
  logic [TAGW-1:0]   rr_ptr;
  logic [FW-1:0]     fcnt;
  logic              nonempty;
  logic              wr_en;
  logic              pop;
  logic              frame_last;

  logic              found;
  logic [TAGW-1:0]   sel;
  logic [DWIDTH-1:0] sel_data;
  logic [DWIDTH-1:0] ld_data;
  logic              load_ok;
  logic              take;
  int                idx;

  assign nonempty     = (count != '0);
  assign fifo_in_full = (count == CW'(DEPTH));
  assign wr_en        = fifo_in_wrreq & ~fifo_in_full;
  assign lane_wdata   = nonempty ? mem[rd_ptr] : '0;

  // A lane is strobed once per head word; reset also silences the strobes
  assign lane_wrreq = (nonempty & ~reset) ? (~done_mask & ~lane_full) : '0;
  assign mask_all   = done_mask | lane_wrreq;
  assign pop        = nonempty & (&mask_all);
  assign frame_last = (fcnt == FW'(FRAME_LEN - 1));
  assign busy       = nonempty | (|done_mask) | out_valid;

  // Pixel storage: plain RAM, contents are don't-care while count is 0
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= fifo_in_data;
  end

  // FIFO pointers, occupancy and per-lane delivered mask
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      done_mask <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (wr_en && !pop)
        count <= count + CW'(1);
      else if (pop && !wr_en)
        count <= count - CW'(1);
      done_mask <= pop ? '0 : mask_all;
    end
  end

  // Frame position counter; frame_done marks retirement of the last word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & frame_last;
      if (pop)
        fcnt <= frame_last ? '0 : fcnt + FW'(1);
    end
  end

  // Round-robin search for the first non-empty lane starting at rr_ptr
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_data = '0;
    idx      = 0;
    for (int k = 0; k < NF; k++) begin
      idx = (int'(rr_ptr) + k) % NF;
      if (!found && !res_empty[idx]) begin
        found    = 1'b1;
        sel      = TAGW'(idx);
        sel_data = res_data[idx*DWIDTH +: DWIDTH];
      end
    end
  end

  assign load_ok = ~out_valid | out_ready;
  assign take    = load_ok & found & ~reset;

  // One-hot pop of the selected lane's result
  always_comb begin
    res_rdreq = '0;
    if (take) res_rdreq[sel] = 1'b1;
  end

`ifdef CONV_FMAP_RELU_EN
  // Negative values (sign bit set) clamp to zero for int and float alike
  assign ld_data = sel_data[DWIDTH-1] ? '0 : sel_data;
`else
  assign ld_data = sel_data;
`endif

  // Output register: load on take, drop valid once accepted with nothing new
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_tag   <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_data  <= ld_data;
      out_tag   <= sel;
      out_valid <= 1'b1;
      rr_ptr    <= (int'(sel) == NF - 1) ? '0 : sel + TAGW'(1);
    end else begin
      out_valid <= out_valid & ~out_ready;
    end
  end

endmodule

// File: tb/tb_conv2d_fmap_broadcast_collect.sv
// Directed bench for conv2d_fmap_broadcast_collect (NF=8, DEPTH=4,
// FRAME_LEN=4). Expected values follow CONV_FMAP_RELU_EN when defined.
module tb_conv2d_fmap_broadcast_collect;

  localparam int DW = 32;
  localparam int CH = 3;
  localparam int NF = 8;
  localparam int TW = 3;

  logic            clock;
  logic            reset;
  logic [CH*DW-1:0] fifo_in_data;
  logic            fifo_in_wrreq;
  logic            fifo_in_full;
  logic [CH*DW-1:0] lane_wdata;
  logic [NF-1:0]   lane_wrreq;
  logic [NF-1:0]   lane_full;
  logic [NF*DW-1:0] res_data;
  logic [NF-1:0]   res_empty;
  logic [NF-1:0]   res_rdreq;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_tag;
  logic            out_valid;
  logic            out_ready;
  logic            frame_done;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int fd_cnt;
  int fd_first;
  int fd_second;

  conv2d_fmap_broadcast_collect #(
    .DWIDTH(DW), .CH(CH), .NF(NF), .DEPTH(4),
    .FRAME_LEN(4), .TAGW(TW)
  ) dut (
    .clock(clock), .reset(reset),
    .fifo_in_data(fifo_in_data), .fifo_in_wrreq(fifo_in_wrreq),
    .fifo_in_full(fifo_in_full), .lane_wdata(lane_wdata),
    .lane_wrreq(lane_wrreq), .lane_full(lane_full),
    .res_data(res_data), .res_empty(res_empty), .res_rdreq(res_rdreq),
    .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    fifo_in_data = '0;
    fifo_in_wrreq = 1'b0;
    lane_full = '0;
    res_data = '0;
    res_empty = '1;
    out_ready = 1'b0;
    do_reset();

    // reset state
    chk("rst_full", fifo_in_full, 0);
    chk("rst_wrreq", lane_wrreq, 0);
    chk("rst_rdreq", res_rdreq, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wdata", lane_wdata, 0);

    // three words, all lanes ready
    fifo_in_wrreq = 1'b1;
    fifo_in_data = 96'd1;
    #1;
    chk("t1_nobypass", lane_wrreq, 0);
    step();
    fifo_in_data = 96'd2;
    #1;
    chk("t1_w1_req", lane_wrreq, 8'hFF);
    chk("t1_w1_dat", lane_wdata, 1);
    step();
    fifo_in_data = 96'd3;
    #1;
    chk("t1_w2_req", lane_wrreq, 8'hFF);
    chk("t1_w2_dat", lane_wdata, 2);
    step();
    fifo_in_wrreq = 1'b0;
    #1;
    chk("t1_w3_req", lane_wrreq, 8'hFF);
    chk("t1_w3_dat", lane_wdata, 3);
    step();
    chk("t1_idle_req", lane_wrreq, 0);
    chk("t1_idle_busy", busy, 0);

    // lane 5 stalled, FIFO fills, extra write dropped
    do_reset();
    lane_full = 8'h20;
    fifo_in_wrreq = 1'b1;
    fifo_in_data = 96'd10;
    step();
    fifo_in_data = 96'd11;
    #1;
    chk("t2_first_req", lane_wrreq, 8'hDF);
    chk("t2_first_dat", lane_wdata, 10);
    step();
    fifo_in_data = 96'd12;
    #1;
    chk("t2_masked_req", lane_wrreq, 0);
    step();
    fifo_in_data = 96'd13;
    step();
    fifo_in_data = 96'd14;
    #1;
    chk("t2_full", fifo_in_full, 1);
    step();
    fifo_in_wrreq = 1'b0;
    #1;
    chk("t2_full_drop", fifo_in_full, 1);
    chk("t2_head_held", lane_wdata, 10);
    repeat (4) step();
    chk("t2_still_full", fifo_in_full, 1);
    lane_full = '0;
    #1;
    chk("t2_rel_req", lane_wrreq, 8'h20);
    chk("t2_rel_dat", lane_wdata, 10);
    step();
    chk("t2_w11_req", lane_wrreq, 8'hFF);
    chk("t2_w11_dat", lane_wdata, 11);
    step();
    chk("t2_w12_dat", lane_wdata, 12);
    step();
    chk("t2_w13_dat", lane_wdata, 13);
    chk("t2_w13_req", lane_wrreq, 8'hFF);
    step();
    chk("t2_drained", lane_wrreq, 0);
    chk("t2_busy", busy, 0);

    // frame_done after pops of word index 3 and 7
    do_reset();
    fd_cnt = 0;
    fd_first = 0;
    fd_second = 0;
    for (int i = 1; i <= 12; i++) begin
      fifo_in_wrreq = (i <= 8);
      fifo_in_data = 96'(i);
      step();
      if (frame_done) begin
        fd_cnt++;
        if (fd_cnt == 1) fd_first = i;
        if (fd_cnt == 2) fd_second = i;
      end
    end
    fifo_in_wrreq = 1'b0;
    chk("t3_fd_count", fd_cnt, 2);
    chk("t3_fd_first", fd_first, 5);
    chk("t3_fd_second", fd_second, 9);

    // collector round robin at full rate
    do_reset();
    for (int i = 0; i < NF; i++)
      res_data[i*DW +: DW] = 32'h100 + 32'(i);
    res_empty = '0;
    out_ready = 1'b1;
    #1;
    chk("t4_rd0", res_rdreq, 8'h01);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t4_valid", out_valid, 1);
      chk("t4_tag", out_tag, i % 8);
      chk("t4_data", out_data, 32'h100 + 32'(i % 8));
      chk("t4_rdnext", res_rdreq, 8'h01 << ((i + 1) % 8));
    end
    out_ready = 1'b0;
    #1;
    chk("t4_stall_rd", res_rdreq, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_data", out_data, 32'h100);
      chk("t4_hold_tag", out_tag, 0);
      chk("t4_hold_rd", res_rdreq, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_resume_rd", res_rdreq, 8'h02);

    // ReLU path and reset mid-stream
    do_reset();
    res_empty = 8'hFE;
    res_data = '0;
    res_data[31:0] = 32'hBF800000;
    out_ready = 1'b1;
    step();
`ifdef CONV_FMAP_RELU_EN
    chk("t6_neg", out_data, 0);
`else
    chk("t6_neg", out_data, 32'hBF800000);
`endif
    chk("t6_neg_tag", out_tag, 0);
    res_data[31:0] = 32'h3F800000;
    step();
    chk("t6_pos", out_data, 32'h3F800000);
    chk("t6_pos_tag", out_tag, 0);
    fifo_in_wrreq = 1'b1;
    fifo_in_data = 96'd77;
    step();
    fifo_in_wrreq = 1'b0;
    #1;
    chk("t6_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wrreq", lane_wrreq, 0);
    chk("t6_rst_rdreq", res_rdreq, 0);
    chk("t6_rst_wdata", lane_wdata, 0);
    chk("t6_rst_full", fifo_in_full, 0);
    step();
    reset = 1'b0;
    res_empty = '1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv2d_fmap_broadcast_collect.md
Name: conv2d_fmap_broadcast_collect

Overview:
- Parametrised front/back-end for an NF-filter conv2d feature-map layer.
- Buffers packed CH-channel input pixels in one shared FIFO instead of one FIFO per filter.
- Broadcasts each pixel word to NF filter-core lanes with independent per-lane back-pressure.
- Collects lane results round-robin into one tagged output stream feeding the next layer.

Parameters:
- DWIDTH, 32, bits per channel sample and per result word.
- CH, 3, channels packed per input word; input width is CH*DWIDTH.
- NF, 8, number of filter lanes (>=1).
- DEPTH, 12544, input FIFO depth in words.
- FRAME_LEN, 12544, input words per feature map (>=1).
- TAGW, 3, width of lane tag; must satisfy 2^TAGW >= NF.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_in_data  in  CH*DWIDTH  packed input pixel.
- fifo_in_wrreq  in  1  write strobe.
- fifo_in_full  out  1  input FIFO full.
- lane_wdata  out  CH*DWIDTH  broadcast word, shared by all lanes.
- lane_wrreq  out  NF  per-lane write strobe.
- lane_full  in  NF  per-lane almost-full.
- res_data  in  NF*DWIDTH  lane results; lane i occupies bits [i*DWIDTH +: DWIDTH]; show-ahead.
- res_empty  in  NF  per-lane result empty.
- res_rdreq  out  NF  per-lane result pop.
- out_data  out  DWIDTH  collected result.
- out_tag  out  TAGW  index of the source lane.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts.
- frame_done  out  1  one-cycle pulse when the last word of a frame retires.
- busy  out  1  FIFO non-empty, or broadcast in progress, or out_valid.

Behaviour:
- Reset values (async): FIFO count, read pointer and write pointer = 0; done_mask = 0; rr_ptr = 0; frame counter = 0. All outputs 0: fifo_in_full, lane_wrreq, res_rdreq, out_valid, out_data, out_tag, frame_done, busy. lane_wdata = 0 when the FIFO is empty.
- Input FIFO:
  - Registered count; fifo_in_full = (count==DEPTH).
  - Write is accepted when fifo_in_wrreq & ~fifo_in_full. A write while full is dropped and count is unchanged.
  - Show-ahead: lane_wdata = head word whenever count!=0.
  - Simultaneous write and pop: count unchanged. When count==0 a write cannot be popped in the same cycle; first broadcast is the cycle after the write.
  - Pointers wrap from DEPTH-1 to 0.
- Broadcast (combinational strobes, registered mask):
  - lane_wrreq[i] = (count!=0) & ~done_mask[i] & ~lane_full[i].
  - Each cycle: done_mask <= done_mask | lane_wrreq.
  - When (done_mask | lane_wrreq) is all ones: pop the head and clear done_mask to 0 in that cycle.
  - Every lane receives every word exactly once and in order. A lane that is full stalls only itself until the word retires.
  - Latency from accepted write (FIFO empty, all lanes ready) to lane_wrreq: 1 cycle.
- Frame counter:
  - Increments on each pop and wraps at FRAME_LEN-1 -> 0.
  - frame_done is registered: it pulses the cycle after the pop of word FRAME_LEN-1.
- Collector:
  - load_ok = ~out_valid | out_ready.
  - When load_ok: search lanes starting at rr_ptr for the first lane with ~res_empty (wrap NF-1 -> 0); call it sel.
  - If a lane is found: res_rdreq[sel]=1 (combinational, one-hot); next edge out_data <= res_data[sel], out_tag <= sel, out_valid <= 1, rr_ptr <= (sel+1) mod NF.
  - If no lane is found: out_valid <= out_valid & ~out_ready.
  - out_valid & ~out_ready: hold out_data/out_tag stable and drive res_rdreq = 0.
  - Accept and reload in the same cycle sustains 1 word/clock.
  - With all lanes non-empty, successive tags are 0,1,...,NF-1,0.
- Reset mid-operation: all state clears immediately, including any word already in the FIFO or held in out_data. Lanes must be reset by the same signal.

Optional Feature:
- Macro: CONV_FMAP_RELU_EN.
- Defined: the value loaded into out_data is 0 if its MSB is 1, else unchanged. This is valid for both two's-complement and IEEE-754 results. Latency is unchanged.
- Undefined: result words pass through unmodified.

Test Plan:
- Reset, then write 3 words with all lanes ready -> each lane sees words 1,2,3 in order, one per cycle; first lane_wrreq 1 cycle after the first write; busy returns to 0.
- Hold lane_full[5]=1 for 10 cycles while streaming -> other lanes take word 0 only; FIFO fills; on release lane 5 takes word 0, then all lanes resume; no loss or duplication.
- NF=8, FRAME_LEN=4, stream 8 words -> frame_done pulses exactly twice, one cycle after pops 3 and 7.
- All 8 result lanes non-empty, out_ready=1 -> out_tag sequence 0..7,0 at 1 word/clock; with out_ready=0 for 3 cycles, out_data stays held and res_rdreq=0.
- Fill FIFO to DEPTH, pulse fifo_in_wrreq again -> fifo_in_full=1, the extra write is dropped, count stays DEPTH.
- CONV_FMAP_RELU_EN defined, lane result 0xBF800000 -> out_data=0; result 0x3F800000 -> out_data=0x3F800000; assert reset mid-stream -> all outputs 0 in the same cycle.
